instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

- Fetch/decode front end for one core.
- Drives the registered-read instruction memory, assembles one- and two-word instructions, and presents them to the core's control unit over a valid/ready handshake.
- Follows JPNZ redirects resolved by the execute stage and stops on END.

## Interface
- PC_RESET, 16'h0000, PC value loaded on reset
- ADDR_W, 16, program-counter / memory address width
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_read  out  1  read strobe to instruction memory
- mem_addr  out  ADDR_W  word address to instruction memory
- mem_data  in  16  memory read data, valid the cycle after mem_read, {field[15:8], opcode[7:0]}
- instr_valid  out  1  decoded instruction available
- instr_ready  in  1  control unit accepts instruction
- instr_opcode  out  8  opcode byte
- instr_field  out  8  register/step selector byte
- instr_imm  out  16  second word of two-word instructions, else 0
- instr_pc  out  ADDR_W  address of the instruction's first word
- br_done  in  1  execute stage has resolved the outstanding JPNZ
- br_taken  in  1  with br_done: jump taken
- halted  out  1  END accepted, fetch stopped
- illegal  out  1  unknown opcode trapped (0 unless IFETCH_ILLEGAL_TRAP_EN)

## Operation
- Opcodes: CLAC 4, LOAD 5, INDAC 9, MVAC 11, COPY 12, STOR 13, JPNZ 16, LODM 20, ADD 23, SUB 25, MUL 27, END 30.
- Two-word opcodes are LOAD and JPNZ. All other opcodes are single-word.
- FSM states: FETCH1, CAP1, FETCH2, CAP2, ISSUE, BR_WAIT, HALT.
- FETCH1: mem_read=1, mem_addr=pc. Next state is CAP1.
- CAP1:
  - Latch opcode/field from mem_data, instr_pc<=pc, pc<=pc+1, imm<=0.
  - Next state is FETCH2 if two-word, else ISSUE.
- FETCH2: mem_read=1, mem_addr=pc. Next state is CAP2.
- CAP2: imm<=mem_data, pc<=pc+1. Next state is ISSUE.
- ISSUE:
  - instr_valid=1 and all instr_* outputs held stable until instr_ready is sampled high.
  - On handshake:
    - JPNZ goes to BR_WAIT.
    - END goes to HALT.
    - Anything else goes to FETCH1.
- BR_WAIT:
  - mem_read=0 until br_done.
  - br_taken=1 loads pc<=imm; br_taken=0 keeps pc, which already points past the target word.
  - Next state is FETCH1.
  - br_done in the same cycle as the ISSUE handshake is ignored.
- HALT: halted=1, mem_read=0, instr_valid=0. The block stays in HALT until reset.
- pc arithmetic is modulo 2^ADDR_W: 16'hFFFF+1 wraps to 0, including a two-word instruction straddling the wrap.
- mem_read is 0 in every state except FETCH1/FETCH2. mem_addr holds pc in all states.

## Timing
- Reset (rst low, async):
  - State goes to FETCH1 and pc to PC_RESET.
  - instr_valid, halted, illegal, mem_read are 0 and all instr_* are 0.
  - The first mem_read comes on the first edge after release.
- Single-word latency is 3 cycles from FETCH1 to instr_valid. Two-word latency is 5 cycles.
- Throughput with instr_ready tied high:
  - One single-word instruction per 3 cycles.
  - For JPNZ, add BR_WAIT cycles plus 1.
- A reset asserted in any state, including mid two-word assembly, discards the partial instruction with no output glitch after the reset edge.

## Configuration
- IFETCH_ILLEGAL_TRAP_EN defined:
  - An opcode outside the table sets illegal=1 in CAP1 and the block enters HALT with halted=1.
  - The instruction is not issued. illegal is sticky until reset.
- IFETCH_ILLEGAL_TRAP_EN undefined:
  - Unknown opcodes are issued as single-word instructions unchanged.
  - illegal is tied to 0.

## Structure
- ifetch_pkg holds:
  - opcode localparams
  - the FSM state enum
  - the two-word/branch/end classification constants
- One sub-module, ifetch_classify: combinational opcode classifier with outputs is_two_word, is_branch, is_end, is_legal. It is instantiated in CAP1.

## Test plan
- Single-word fetch:
  - Stimulus: release reset, mem word0={8'd0,8'd4}, instr_ready=1.
  - Response: instr_valid in cycle 3, opcode=4, field=0, imm=0, instr_pc=0; next mem_addr=1.
- LOAD assembly:
  - Stimulus: words 5,6 = {8'd6,8'd5},{8'd0,8'd1}.
  - Response: opcode=5, field=6, imm=1, instr_pc=5; next fetch at address 7.
- JPNZ branch:
  - Stimulus: words 77,78 = {0,16},{0,28}.
  - Response with br_done with br_taken=1: next mem_addr=28.
  - Response with br_taken=0: next mem_addr=79.
- Backpressure:
  - Stimulus: instr_ready low for 5 cycles in ISSUE.
  - Response: all instr_* outputs stable, mem_read=0, instruction accepted once on release.
- END then reset:
  - Stimulus: word {0,30} at address 86, then hold 20 cycles, then assert rst mid-CAP2 of a later LOAD.
  - Response: halted=1 with no further mem_read; after reset all outputs are 0 and fetching restarts at 0.
- Illegal opcode:
  - Stimulus: word {0,99} with IFETCH_ILLEGAL_TRAP_EN.
  - Response: illegal=1, halted=1, instr_valid never asserted.
  - Response without the macro: issued with opcode=99.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared opcode table, fetch FSM state encoding and opcode classification
// constants for the instruction fetch front end.
package ifetch_pkg;

    localparam logic [7:0] OP_CLAC  = 8'd4;
    localparam logic [7:0] OP_LOAD  = 8'd5;
    localparam logic [7:0] OP_INDAC = 8'd9;
    localparam logic [7:0] OP_MVAC  = 8'd11;
    localparam logic [7:0] OP_COPY  = 8'd12;
    localparam logic [7:0] OP_STOR  = 8'd13;
    localparam logic [7:0] OP_JPNZ  = 8'd16;
    localparam logic [7:0] OP_LODM  = 8'd20;
    localparam logic [7:0] OP_ADD   = 8'd23;
    localparam logic [7:0] OP_SUB   = 8'd25;
    localparam logic [7:0] OP_MUL   = 8'd27;
    localparam logic [7:0] OP_END   = 8'd30;

    // Instructions carrying a second (immediate) word.
    localparam logic [7:0] TWO_WORD_OP_A = OP_LOAD;
    localparam logic [7:0] TWO_WORD_OP_B = OP_JPNZ;
    // The only redirecting opcode, and the one that stops fetch.
    localparam logic [7:0] BRANCH_OP     = OP_JPNZ;
    localparam logic [7:0] END_OP        = OP_END;

    typedef enum logic [2:0] {
        FETCH1  = 3'd0,
        CAP1    = 3'd1,
        FETCH2  = 3'd2,
        CAP2    = 3'd3,
        ISSUE   = 3'd4,
        BR_WAIT = 3'd5,
        HALT    = 3'd6
    } ifetch_state_e;

    function automatic logic op_in_table(input logic [7:0] op);
        case (op)
            OP_CLAC, OP_LOAD, OP_INDAC, OP_MVAC, OP_COPY, OP_STOR,
            OP_JPNZ, OP_LODM, OP_ADD, OP_SUB, OP_MUL, OP_END: op_in_table = 1'b1;
            default:                                          op_in_table = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ifetch_classify.sv
// Combinational opcode classifier used while the first instruction word is
// being captured.
module ifetch_classify
    import ifetch_pkg::*;
(
    input  logic [7:0] opcode_i,
    output logic       is_two_word,
    output logic       is_branch,
    output logic       is_end,
    output logic       is_legal
);

    always_comb begin
        is_two_word = (opcode_i == TWO_WORD_OP_A) || (opcode_i == TWO_WORD_OP_B);
        is_branch   = (opcode_i == BRANCH_OP);
        is_end      = (opcode_i == END_OP);
        is_legal    = op_in_table(opcode_i);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/decode front end: reads one- and two-word instructions from a
// registered-read memory and hands them to the control unit over valid/ready.
// Optional feature macro: IFETCH_ILLEGAL_TRAP_EN (trap unknown opcodes into HALT).
module instr_fetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]    PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_opcode,
    output logic [7:0]        instr_field,
    output logic [15:0]       instr_imm,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              br_done,
    input  logic              br_taken,
    output logic              halted,
    output logic              illegal,
    output ifetch_state_e     dbg_state
);

    // Handshake: instr_valid rises with a complete instruction and, together
    // with every instr_* field, stays unchanged until a rising edge samples
    // instr_ready high; that edge is the single transfer of the instruction.

    ifetch_state_e     state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc_d;
    logic              mem_read_q;
    logic              instr_valid_q;
    logic              halted_q;
    logic [7:0]        opcode_q;
    logic [7:0]        field_q;
    logic [15:0]       imm_q;
    logic [ADDR_W-1:0] ipc_q;
    logic              branch_q;
    logic              end_q;

    logic              is_two_word;
    logic              is_branch;
    logic              is_end;
    logic              is_legal;

    ifetch_classify u_classify (
        .opcode_i    (mem_data[7:0]),
        .is_two_word (is_two_word),
        .is_branch   (is_branch),
        .is_end      (is_end),
        .is_legal    (is_legal)
    );

    assign pc_inc_d = pc_q + ADDR_W'(1);

`ifdef IFETCH_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign illegal = illegal_q;
`else
    logic legal_unused;
    assign legal_unused = is_legal;
    assign illegal      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= FETCH1;
            pc_q          <= PC_RESET;
            mem_read_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            opcode_q      <= '0;
            field_q       <= '0;
            imm_q         <= '0;
            ipc_q         <= '0;
            branch_q      <= 1'b0;
            end_q         <= 1'b0;
`ifdef IFETCH_ILLEGAL_TRAP_EN
            illegal_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                // mem_read is registered alongside the state, so the only time
                // FETCH1 is seen without a read in flight is right after reset.
                FETCH1: begin
                    if (mem_read_q) begin
                        mem_read_q <= 1'b0;
                        state_q    <= CAP1;
                    end else begin
                        mem_read_q <= 1'b1;
                    end
                end
                CAP1: begin
`ifdef IFETCH_ILLEGAL_TRAP_EN
                    if (!is_legal) begin
                        illegal_q <= 1'b1;
                        halted_q  <= 1'b1;
                        state_q   <= HALT;
                    end else
`endif
                    begin
                        opcode_q <= mem_data[7:0];
                        field_q  <= mem_data[15:8];
                        ipc_q    <= pc_q;
                        pc_q     <= pc_inc_d;
                        imm_q    <= '0;
                        branch_q <= is_branch;
                        end_q    <= is_end;
                        if (is_two_word) begin
                            mem_read_q <= 1'b1;
                            state_q    <= FETCH2;
                        end else begin
                            instr_valid_q <= 1'b1;
                            state_q       <= ISSUE;
                        end
                    end
                end
                FETCH2: begin
                    mem_read_q <= 1'b0;
                    state_q    <= CAP2;
                end
                CAP2: begin
                    imm_q         <= mem_data;
                    pc_q          <= pc_inc_d;
                    instr_valid_q <= 1'b1;
                    state_q       <= ISSUE;
                end
                // br_done is not looked at here, so a resolution arriving in
                // the handshake cycle itself cannot redirect the wrong branch.
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        if (branch_q) begin
                            state_q <= BR_WAIT;
                        end else if (end_q) begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end else begin
                            mem_read_q <= 1'b1;
                            state_q    <= FETCH1;
                        end
                    end
                end
                BR_WAIT: begin
                    if (br_done) begin
                        if (br_taken) begin
                            pc_q <= ADDR_W'(imm_q);
                        end
                        mem_read_q <= 1'b1;
                        state_q    <= FETCH1;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    mem_read_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                    state_q       <= FETCH1;
                end
            endcase
        end
    end

    assign mem_read     = mem_read_q;
    assign mem_addr     = pc_q;
    assign instr_valid  = instr_valid_q;
    assign instr_opcode = opcode_q;
    assign instr_field  = field_q;
    assign instr_imm    = imm_q;
    assign instr_pc     = ipc_q;
    assign halted       = halted_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a memory model serves a small program,
// a scoreboard queue holds expected issued instructions, a monitor checks them.
module tb_instr_fetch_unit;
  import ifetch_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_read;
  logic [15:0]   mem_addr;
  logic [15:0]   mem_data = 16'h0000;
  logic          instr_valid;
  logic          instr_ready = 1'b1;
  logic [7:0]    instr_opcode;
  logic [7:0]    instr_field;
  logic [15:0]   instr_imm;
  logic [15:0]   instr_pc;
  logic          br_done = 1'b0;
  logic          br_taken = 1'b0;
  logic          halted;
  logic          illegal;
  ifetch_state_e dbg_state;

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];
  logic [15:0] mem [0:65535];

  instr_fetch_unit #(.ADDR_W(16), .PC_RESET(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_data(mem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_field(instr_field),
    .instr_imm(instr_imm), .instr_pc(instr_pc),
    .br_done(br_done), .br_taken(br_taken),
    .halted(halted), .illegal(illegal), .dbg_state(dbg_state)
  );

  // clock / memory model (registered read)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_read) mem_data <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] f, input logic [15:0] imm, input logic [15:0] pc);
    exp_q.push_back({op, f, imm, pc});
  endtask

  task automatic wait_issue(input logic [15:0] pc);
    int n = 0;
    while (!(instr_valid && instr_pc == pc) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) timeout($sformatf("wait_issue_%0h", pc));
  endtask

  task automatic wait_state(input ifetch_state_e s);
    int n = 0;
    while (dbg_state != s && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) timeout($sformatf("wait_state_%0d", s));
  endtask

  task automatic resolve(input logic taken, input logic [15:0] target);
    wait_state(BR_WAIT);
    check("br_wait_no_read", 64'(mem_read), 64'd0);
    br_done  = 1'b1;
    br_taken = taken;
    tick();
    br_done  = 1'b0;
    br_taken = 1'b0;
    check($sformatf("redirect_addr_%0h", target), 64'(mem_addr), 64'(target));
    check("redirect_read", 64'(mem_read), 64'd1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({mem_read, instr_valid, halted, illegal, instr_opcode,
                     instr_field, instr_imm, instr_pc, mem_addr}), 64'd0);
    check({name, "_state"}, 64'(dbg_state), 64'(FETCH1));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got opcode %0d at pc %0h, expected none",
                 instr_opcode, instr_pc);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        check($sformatf("issue_pc_%0h", e[15:0]),
              64'({instr_opcode, instr_field, instr_imm, instr_pc}), 64'(e));
      end
    end
  end

  initial begin
    logic [47:0] snap;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0]  = {8'd0, 8'd4};
    mem[1]  = {8'd3, 8'd11};
    mem[2]  = {8'd0, 8'd23};
    mem[3]  = {8'd0, 8'd12};
    mem[4]  = {8'd0, 8'd13};
    mem[5]  = {8'd6, 8'd5};
    mem[6]  = {8'd0, 8'd1};
    mem[7]  = {8'd2, 8'd25};
    mem[8]  = {8'd0, 8'd16};
    mem[9]  = 16'd77;
    mem[10] = {8'd0, 8'd27};
    mem[11] = {8'd0, 8'd16};
    mem[12] = 16'd77;
    mem[77] = {8'd0, 8'd16};
    mem[78] = 16'd28;
    mem[28] = {8'd0, 8'd99};
    mem[29] = {8'd5, 8'd20};
    mem[30] = {8'd0, 8'd9};
    mem[31] = {8'd0, 8'd16};
    mem[32] = 16'd86;
    mem[86] = {8'd0, 8'd30};

    // reset block
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    push(8'd4, 8'd0, 16'd0, 16'd0);
    push(8'd11, 8'd3, 16'd0, 16'd1);
    push(8'd23, 8'd0, 16'd0, 16'd2);
    push(8'd12, 8'd0, 16'd0, 16'd3);
    push(8'd13, 8'd0, 16'd0, 16'd4);
    push(8'd5, 8'd6, 16'd1, 16'd5);
    push(8'd25, 8'd2, 16'd0, 16'd7);
    push(8'd16, 8'd0, 16'd77, 16'd8);
    push(8'd27, 8'd0, 16'd0, 16'd10);
    push(8'd16, 8'd0, 16'd77, 16'd11);
    push(8'd16, 8'd0, 16'd28, 16'd77);
`ifndef IFETCH_ILLEGAL_TRAP_EN
    push(8'd99, 8'd0, 16'd0, 16'd28);
    push(8'd20, 8'd5, 16'd0, 16'd29);
    push(8'd9, 8'd0, 16'd0, 16'd30);
    push(8'd16, 8'd0, 16'd86, 16'd31);
    push(8'd30, 8'd0, 16'd0, 16'd86);
`endif

    @(negedge clk);
    rst = 1'b1;
    tick();
    check("first_read", 64'({mem_read, mem_addr}), 64'({1'b1, 16'h0000}));
    tick();
    check("cycle2_no_valid", 64'(instr_valid), 64'd0);
    tick();
    check("cycle3_valid", 64'(instr_valid), 64'd1);
    tick();
    check("next_addr_after_clac", 64'({mem_read, mem_addr}), 64'({1'b1, 16'h0001}));

    wait_issue(16'd5);
    tick();
    check("next_addr_after_load", 64'(mem_addr), 64'd7);

    // br_done coinciding with the JPNZ handshake must be ignored
    wait_issue(16'd8);
    br_done  = 1'b1;
    br_taken = 1'b1;
    tick();
    br_done  = 1'b0;
    br_taken = 1'b0;
    check("br_done_in_handshake_ignored", 64'(dbg_state), 64'(BR_WAIT));
    tick();
    tick();
    check("br_wait_holds", 64'({dbg_state, mem_read}), 64'({BR_WAIT, 1'b0}));
    resolve(1'b0, 16'd10);

    // backpressure on MUL
    instr_ready = 1'b0;
    wait_issue(16'd10);
    snap = {instr_opcode, instr_field, instr_imm, instr_pc};
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_stable_%0d", i),
            64'({instr_valid, mem_read, instr_opcode, instr_field, instr_imm, instr_pc}),
            64'({1'b1, 1'b0, snap}));
    end
    instr_ready = 1'b1;
    tick();
    check("stall_released", 64'({instr_valid, dbg_state}), 64'({1'b0, FETCH1}));

    resolve(1'b1, 16'd77);
    resolve(1'b1, 16'd28);

`ifndef IFETCH_ILLEGAL_TRAP_EN
    resolve(1'b1, 16'd86);
`endif
    begin
      int n = 0;
      while (!halted && n < 300) begin
        tick();
        n++;
      end
      if (n >= 300) timeout("wait_halt");
    end
`ifdef IFETCH_ILLEGAL_TRAP_EN
    check("illegal_flag", 64'(illegal), 64'd1);
`else
    check("illegal_flag", 64'(illegal), 64'd0);
`endif
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("halt_hold_%0d", i), 64'({halted, mem_read, instr_valid}), 64'(3'b100));
    end

    // reset out of HALT, then reset again mid two-word assembly
    rst = 1'b0;
    #1;
    check_all_zero("reset_from_halt");
    push(8'd4, 8'd0, 16'd0, 16'd0);
    push(8'd11, 8'd3, 16'd0, 16'd1);
    push(8'd23, 8'd0, 16'd0, 16'd2);
    push(8'd12, 8'd0, 16'd0, 16'd3);
    push(8'd13, 8'd0, 16'd0, 16'd4);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("restart_read", 64'({mem_read, mem_addr}), 64'({1'b1, 16'h0000}));
    wait_state(CAP2);
    #2 rst = 1'b0;
    #1;
    check_all_zero("reset_mid_cap2");
    check("partial_discarded_queue", 64'(exp_q.size()), 64'd0);

    // wrap: JPNZ to 16'hFFFF, LOAD straddling the top of memory
    mem[1]     = {8'd0, 8'd16};
    mem[2]     = 16'hFFFF;
    mem[16'hFFFF] = {8'd7, 8'd5};
    push(8'd4, 8'd0, 16'd0, 16'd0);
    push(8'd16, 8'd0, 16'hFFFF, 16'd1);
    push(8'd5, 8'd7, 16'h0004, 16'hFFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("restart2_read", 64'({mem_read, mem_addr}), 64'({1'b1, 16'h0000}));
    wait_issue(16'd1);
    resolve(1'b1, 16'hFFFF);
    wait_issue(16'hFFFF);
    tick();
    check("wrap_next_addr", 64'({mem_read, mem_addr}), 64'({1'b1, 16'h0001}));
    instr_ready = 1'b0;
    repeat (10) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
